fp_alu_dispatcher: RTL and testbench
====================================

Name: fp_alu_dispatcher

Overview:
Upstream feeder for the floating-point ALU (ports clk, rst, start, a, b, sel, result, overflow, done).
- Accepts operand jobs {sel, a, b} on a valid/ready input stream and buffers them in a small FIFO.
- Issues one job at a time to the ALU with a single-cycle start pulse, then waits for done.
- Returns result/overflow on a valid/ready output stream. A watchdog turns a hung ALU into a flagged NaN response.

Parameters:
DEPTH, 4, operand FIFO entries (power of two, >=2)
TIMEOUT, 16, max cycles in WAIT before the job is aborted (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  job offered
in_ready  out  1  FIFO can accept (not full)
in_a  in  32  IEEE-754 single operand A
in_b  in  32  IEEE-754 single operand B
in_sel  in  1  ALU operation select, passed through unchanged
alu_start  out  1  one-cycle issue pulse to ALU
alu_a  out  32  operand A to ALU, held stable from issue until response
alu_b  out  32  operand B to ALU, held stable from issue until response
alu_sel  out  1  op select to ALU, held stable from issue until response
alu_result  in  32  ALU result
alu_overflow  in  1  ALU overflow flag
alu_done  in  1  ALU completion strobe
out_valid  out  1  response available
out_ready  in  1  consumer accepts response
out_result  out  32  captured result
out_overflow  out  1  captured overflow flag
out_timeout  out  1  response produced by watchdog, not by ALU
busy  out  1  FSM not IDLE or FIFO non-empty
fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
Reset:
- Asynchronous assert. Every output goes to 0 except in_ready, which goes to 1.
- FIFO is emptied, state returns to IDLE, watchdog is cleared.
- Reset mid-job aborts the job silently; no response is produced.

Input side:
- A push occurs when in_valid && in_ready.
- in_ready = (fifo_count < DEPTH), registered-count based.
- When full, in_ready = 0 and the offered job is not consumed.
- A push and a pop in the same cycle leaves fifo_count unchanged.
- FIFO pointers wrap modulo DEPTH.

FSM states:
- IDLE: if fifo_count > 0, pop the head into alu_a/alu_b/alu_sel, clear the watchdog, go to ISSUE. Otherwise stay.
- ISSUE: alu_start = 1 for exactly this cycle, then go to WAIT.
- WAIT: watchdog increments every cycle.
  - On alu_done = 1: register out_result = alu_result, out_overflow = alu_overflow, out_timeout = 0, set out_valid, go to RESP.
  - Else, when the watchdog reaches TIMEOUT-1: out_result = 32'h7FC00000, out_overflow = 0, out_timeout = 1, set out_valid, go to RESP.
  - alu_done and timeout in the same cycle: alu_done wins.
- RESP: hold out_* stable while out_valid && !out_ready. On out_ready, clear out_valid and go to IDLE. If the FIFO is non-empty, the next pop happens in that IDLE cycle.

Other rules:
- alu_done is ignored in IDLE, ISSUE and RESP, so stray strobes have no effect.
- Latency from push edge (FIFO empty, FSM idle):
  - IDLE pop at +1.
  - alu_start high at +2.
  - out_valid high the cycle after alu_done is sampled.
- Throughput: one job per (ALU latency + 3) cycles with out_ready tied high. No overlap of jobs.
- alu_a/alu_b/alu_sel keep their last values outside a job. They are not zeroed.

Decomposition:
- Shared package fp_pkg holds:
  - FP_WIDTH = 32
  - FP_QNAN = 32'h7FC00000
  - FP_INF = 32'h7F800000
  - the dispatcher state encoding IDLE/ISSUE/WAIT/RESP (2 bits)
- One sub-module, fp_operand_fifo:
  - synchronous FIFO, width 65, parameter DEPTH
  - ports: push, pop, din, dout, count, full, empty
  - same clk/rst

Test Plan:
1. Push {sel=0, a=3F800000, b=40000000}; ALU model returns done after 4 cycles with 40000000 -> alu_start is a single pulse 2 cycles after push; out_result = 40000000, out_overflow = 0, out_timeout = 0.
2. Push 7F7FFFFF x 40000000 with ALU returning 7F800000, overflow = 1; out_ready held low 5 cycles -> out_valid and out_result = 7F800000 stay stable until out_ready; then exactly one transfer.
3. With ALU stalled, push 5 jobs back-to-back (41200000 x C1A00000 first) -> in_ready drops after the 4th is buffered, fifo_count = 4; after the ALU is released, responses come out in order, the first being C3480000.
4. ALU never asserts done -> after TIMEOUT cycles in WAIT: out_result = 7FC00000, out_timeout = 1, out_overflow = 0; the next queued job is then issued normally.
5. Assert alu_done while IDLE, and rst mid-WAIT -> no response emitted; after reset all outputs are 0, in_ready = 1, fifo_count = 0.
6. alu_done coincident with the watchdog's last cycle -> the ALU result is reported and out_timeout = 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the FP ALU front end.
// Holds the job bundle layout and the dispatcher state encoding.
package fp_pkg;
  localparam int FP_WIDTH = 32;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP_INF = 32'h7F800000;
  localparam int JOB_W = 2 * FP_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } disp_state_t;

  typedef struct packed {
    logic                sel;
    logic [FP_WIDTH-1:0] a;
    logic [FP_WIDTH-1:0] b;
  } fp_job_t;
endpackage

// File: rtl/fp_operand_fifo.sv
// Synchronous operand FIFO; pointers wrap modulo DEPTH.
// Push when full and pop when empty are ignored.
module fp_operand_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fp_alu_dispatcher.sv
// Feeds buffered operand jobs to the FP ALU one at a time.
// A watchdog converts a hung ALU into a flagged quiet-NaN response.
module fp_alu_dispatcher
  import fp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic                       in_sel,
  output logic                       alu_start,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic                       alu_sel,
  input  logic [31:0]                alu_result,
  input  logic                       alu_overflow,
  input  logic                       alu_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic                       out_overflow,
  output logic                       out_timeout,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  disp_state_t   state;
  logic [WW-1:0] wdog;
  fp_job_t       head;
  fp_job_t       job_in;
  logic          full;
  logic          empty;
  logic          pop;

  assign job_in   = '{sel: in_sel, a: in_a, b: in_b};
  assign in_ready = !full;
  assign pop      = (state == IDLE) && !empty;
  assign busy     = (state != IDLE) || !empty;

  fp_operand_fifo #(
    .DEPTH(DEPTH),
    .W    (JOB_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (in_valid && in_ready),
    .pop  (pop),
    .din  (job_in),
    .dout (head),
    .count(fifo_count),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wdog         <= '0;
      alu_start    <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_overflow <= 1'b0;
      out_timeout  <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            alu_a     <= head.a;
            alu_b     <= head.b;
            alu_sel   <= head.sel;
            wdog      <= '0;
            alu_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // a done strobe on the watchdog's last cycle still wins
          if (alu_done) begin
            out_result   <= alu_result;
            out_overflow <= alu_overflow;
            out_timeout  <= 1'b0;
            out_valid    <= 1'b1;
            state        <= RESP;
          end else if (wdog == WW'(TIMEOUT - 1)) begin
            out_result   <= FP_QNAN;
            out_overflow <= 1'b0;
            out_timeout  <= 1'b1;
            out_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_alu_dispatcher.sv
// Scoreboard bench for fp_alu_dispatcher with a behavioural ALU.
// Expected responses are queued at issue and checked by a monitor.
module tb_fp_alu_dispatcher;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sel;
  logic        alu_start;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_sel;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        alu_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_timeout;
  logic        busy;
  logic [2:0]  fifo_count;

  fp_alu_dispatcher #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_sel      (in_sel),
    .alu_start   (alu_start),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .alu_overflow(alu_overflow),
    .alu_done    (alu_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_overflow(out_overflow),
    .out_timeout (out_timeout),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        hang;
    int          lat;
  } alu_ent_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        to;
  } exp_t;

  alu_ent_t alu_q[$];
  exp_t     exp_q[$];
  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  int       start_cyc = 0;
  int       push_cyc = 0;
  logic     stray = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "bench time limit");
  end

  // Behavioural ALU: done strobe is sampled lat edges after start
  initial begin
    int       cnt;
    logic     pend;
    logic     prev;
    alu_ent_t cur;
    pend = 1'b0;
    prev = 1'b0;
    cnt  = 0;
    alu_done = 1'b0;
    alu_result = '0;
    alu_overflow = 1'b0;
    forever begin
      @(negedge clk);
      alu_done = 1'b0;
      alu_result = '0;
      alu_overflow = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (stray) begin
          alu_done = 1'b1;
          alu_result = 32'hDEADBEEF;
          alu_overflow = 1'b1;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            pend = 1'b0;
            alu_done = 1'b1;
            alu_result = cur.res;
            alu_overflow = cur.ovf;
          end
        end
        if (alu_start) begin
          chk("start_pulse_width", prev, 0);
          start_cyc = cyc;
          if (alu_q.size() == 0) begin
            chk("start_without_job", 1, 0);
          end else begin
            cur = alu_q.pop_front();
            chk("alu_a", alu_a, cur.a);
            chk("alu_b", alu_b, cur.b);
            chk("alu_sel", alu_sel, cur.sel);
            if (!cur.hang) begin
              pend = 1'b1;
              cnt = cur.lat;
            end
          end
        end
      end
      prev = alu_start;
    end
  end

  initial forever begin
    exp_t x;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", out_result, 32'hXXXXXXXX);
      end else begin
        x = exp_q.pop_front();
        chk("resp_result", out_result, x.res);
        chk("resp_overflow", out_overflow, x.ovf);
        chk("resp_timeout", out_timeout, x.to);
      end
    end
  end

  task automatic push_job(input logic sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res,
                          input logic ovf, input logic hang, input int lat,
                          input logic want, input logic [31:0] eres,
                          input logic eovf, input logic eto);
    alu_ent_t e;
    exp_t     x;
    int       n;
    @(negedge clk);
    in_valid = 1'b1;
    in_sel = sel;
    in_a = a;
    in_b = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_wait", in_ready, 1);
    push_cyc = cyc;
    e.sel = sel;
    e.a = a;
    e.b = b;
    e.res = res;
    e.ovf = ovf;
    e.hang = hang;
    e.lat = lat;
    alu_q.push_back(e);
    if (want) begin
      x.res = eres;
      x.ovf = eovf;
      x.to = eto;
      exp_q.push_back(x);
    end
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk(nm, out_valid, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_sb", exp_q.size(), 0);
  endtask

  task automatic check_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_overflow", out_overflow, 0);
    chk("rst_out_timeout", out_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_sel = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    #1 check_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // stray done strobes while idle
    @(posedge clk);
    #1 stray = 1'b1;
    repeat (2) @(posedge clk);
    #1 stray = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_valid", out_valid, 0);
    chk("stray_busy", busy, 0);

    // basic job and latency
    push_job(0, 32'h3F800000, 32'h40000000, 32'h40000000, 0, 0, 4,
             1, 32'h40000000, 0, 0);
    idle_in();
    wait_valid("t1_valid_wait");
    chk("t1_start_lat", start_cyc - push_cyc, 2);
    chk("t1_valid_lat", cyc - push_cyc, 7);
    wait_drain();

    // backpressure on the response
    @(posedge clk);
    #1 out_ready = 1'b0;
    push_job(0, 32'h7F7FFFFF, 32'h40000000, FP_INF, 1, 0, 3,
             1, FP_INF, 1, 0);
    idle_in();
    wait_valid("t2_valid_wait");
    repeat (5) begin
      @(negedge clk);
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_result", out_result, FP_INF);
      chk("t2_hold_ovf", out_overflow, 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t2_cleared", out_valid, 0);
    chk("t2_sb_empty", exp_q.size(), 0);
    wait_drain();

    // fill the FIFO behind a slow job
    push_job(0, 32'h41200000, 32'hC1A00000, 32'hC3480000, 0, 0, 14,
             1, 32'hC3480000, 0, 0);
    push_job(0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, 2,
             1, 32'h3F800000, 0, 0);
    push_job(1, 32'h40400000, 32'h40800000, 32'h41400000, 0, 0, 2,
             1, 32'h41400000, 0, 0);
    push_job(0, 32'hBF800000, 32'h40A00000, 32'hC0A00000, 0, 0, 2,
             1, 32'hC0A00000, 0, 0);
    push_job(1, 32'h00000000, 32'h42C80000, 32'h00000000, 0, 0, 2,
             1, 32'h00000000, 0, 0);
    @(negedge clk);
    in_a = 32'h12345678;
    in_b = 32'h9ABCDEF0;
    chk("t3_full_count", fifo_count, 4);
    chk("t3_full_ready", in_ready, 0);
    chk("t3_busy", busy, 1);
    repeat (3) begin
      @(negedge clk);
      chk("t3_held_ready", in_ready, 0);
      chk("t3_held_count", fifo_count, 4);
    end
    in_valid = 1'b0;
    wait_drain();

    // hung ALU, then a normal job
    push_job(0, 32'h40000000, 32'h40000000, 32'h0, 0, 1, 0,
             1, FP_QNAN, 0, 1);
    push_job(0, 32'h40400000, 32'h40000000, 32'h40C00000, 0, 0, 2,
             1, 32'h40C00000, 0, 0);
    idle_in();
    wait_valid("t4_valid_wait");
    chk("t4_timeout_lat", cyc - start_cyc, 17);
    wait_drain();

    // done on the watchdog's last cycle
    push_job(1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1, 0, 16,
             1, 32'h3F800000, 1, 0);
    idle_in();
    wait_drain();

    // reset while a job is in WAIT
    push_job(0, 32'h40000000, 32'h40400000, 32'h0, 0, 1, 0,
             0, 32'h0, 0, 0);
    push_job(1, 32'h40800000, 32'h40A00000, 32'h0, 0, 1, 0,
             0, 32'h0, 0, 0);
    idle_in();
    repeat (6) @(negedge clk);
    chk("t5_busy", busy, 1);
    chk("t5_count", fifo_count, 1);
    #2 rst = 1'b1;
    #1 check_reset();
    alu_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("t5_no_resp", out_valid, 0);
    chk("t5_idle", busy, 0);
    chk("t5_count_after", fifo_count, 0);
    chk("final_sb", exp_q.size(), 0);
    chk("final_alu_q", alu_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
